// File: rtl/writeback_stage.sv
// Final pipeline stage: drives the register-file write port and forwarding bus,
// waits on the data cache for pending loads/stores, counts retired writes.
module writeback_stage #(
  parameter int WORD_WIDTH           = 32,
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int MEM_TIMEOUT          = 64,
  parameter int COUNT_WIDTH          = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WORD_WIDTH-1:0]           instruction_in,
  input  logic [WORD_WIDTH-1:0]           dst_reg_data_in,
  input  logic [WORD_WIDTH-1:0]           mem_data_in,
  input  logic                            cu_mem_to_reg_in,
  input  logic                            cu_reg_write_in,
  input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
  input  logic                            cu_d_cache_access_in,
  input  logic                            dcache_op_done_in,
  output logic                            rf_write_enable_out,
  output logic [REGISTER_INDEX_WIDTH-1:0] rf_write_index_out,
  output logic [WORD_WIDTH-1:0]           rf_write_data_out,
  output logic                            fwd_valid_out,
  output logic [REGISTER_INDEX_WIDTH-1:0] fwd_index_out,
  output logic [WORD_WIDTH-1:0]           fwd_data_out,
  output logic                            stall_out,
  output logic [WORD_WIDTH-1:0]           retired_instruction_out,
  output logic [COUNT_WIDTH-1:0]          retire_count_out,
  output logic                            mem_error_out
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  // The counter never has to hold more than MEM_TIMEOUT-2 before the error exit.
  localparam int              CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 2);

  logic [0:0]                      state_reg, state_next;
  logic [CNT_W-1:0]                cnt_reg, cnt_next;
  logic                            err_next;
  logic                            latch_en;
  logic [REGISTER_INDEX_WIDTH-1:0] lat_index_reg;
  logic                            lat_m2r_reg;
  logic                            lat_rw_reg;
  logic [WORD_WIDTH-1:0]           lat_instr_reg;
  logic [WORD_WIDTH-1:0]           lat_alu_reg;

  logic                            we_reg;
  logic [REGISTER_INDEX_WIDTH-1:0] idx_reg;
  logic [WORD_WIDTH-1:0]           data_reg;
  logic [WORD_WIDTH-1:0]           retired_reg;
  logic [COUNT_WIDTH-1:0]          count_reg;
  logic                            err_reg;

  logic                            commit_req;
  logic                            commit_rw;
  logic                            commit_fire;
  logic [REGISTER_INDEX_WIDTH-1:0] commit_index;
  logic [WORD_WIDTH-1:0]           commit_data;
  logic [WORD_WIDTH-1:0]           commit_instr;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    latch_en     = 1'b0;
    commit_req   = 1'b0;
    commit_rw    = cu_reg_write_in;
    commit_index = destination_register_in;
    commit_instr = instruction_in;
    commit_data  = dst_reg_data_in;
    case (state_reg)
      IDLE: begin
        if (cu_d_cache_access_in) begin
          if (!dcache_op_done_in) begin
            state_next = WAIT_MEM;
            latch_en   = 1'b1;
            cnt_next   = '0;
          end else begin
            commit_req  = 1'b1;
            commit_data = cu_mem_to_reg_in ? mem_data_in : dst_reg_data_in;
          end
        end else if (cu_reg_write_in) begin
          commit_req = 1'b1;
        end
      end
      default: begin
        // Upstream fields are frozen in the latches while the cache is pending.
        commit_rw    = lat_rw_reg;
        commit_index = lat_index_reg;
        commit_instr = lat_instr_reg;
        commit_data  = lat_m2r_reg ? mem_data_in : lat_alu_reg;
        if (dcache_op_done_in) begin
          commit_req = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    endcase
  end

  assign commit_fire = commit_req && commit_rw && (commit_index != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      lat_index_reg <= '0;
      lat_m2r_reg   <= 1'b0;
      lat_rw_reg    <= 1'b0;
      lat_instr_reg <= '0;
      lat_alu_reg   <= '0;
      we_reg        <= 1'b0;
      idx_reg       <= '0;
      data_reg      <= '0;
      retired_reg   <= '0;
      count_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      we_reg    <= commit_fire;
      if (latch_en) begin
        lat_index_reg <= destination_register_in;
        lat_m2r_reg   <= cu_mem_to_reg_in;
        lat_rw_reg    <= cu_reg_write_in;
        lat_instr_reg <= instruction_in;
        lat_alu_reg   <= dst_reg_data_in;
      end
      if (commit_fire) begin
        idx_reg     <= commit_index;
        data_reg    <= commit_data;
        retired_reg <= commit_instr;
        count_reg   <= count_reg + 1'b1;
      end
    end
  end

  assign rf_write_enable_out     = we_reg;
  assign rf_write_index_out      = idx_reg;
  assign rf_write_data_out       = data_reg;
  assign fwd_valid_out           = we_reg;
  assign fwd_index_out           = idx_reg;
  assign fwd_data_out            = data_reg;
  assign stall_out               = (state_reg == WAIT_MEM);
  assign retired_instruction_out = retired_reg;
  assign retire_count_out        = count_reg;
  assign mem_error_out           = err_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage: each operation is modelled as a whole
// transaction (expected strobe cycle, data and stall length), not cycle logic.
module tb_writeback_stage;
  localparam int WW  = 32;
  localparam int RW  = 5;
  localparam int TMO = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WW-1:0] instruction_in = '0;
  logic [WW-1:0] dst_reg_data_in = '0;
  logic [WW-1:0] mem_data_in = '0;
  logic          cu_mem_to_reg_in = 1'b0;
  logic          cu_reg_write_in = 1'b0;
  logic [RW-1:0] destination_register_in = '0;
  logic          cu_d_cache_access_in = 1'b0;
  logic          dcache_op_done_in = 1'b0;
  logic          rf_write_enable_out;
  logic [RW-1:0] rf_write_index_out;
  logic [WW-1:0] rf_write_data_out;
  logic          fwd_valid_out;
  logic [RW-1:0] fwd_index_out;
  logic [WW-1:0] fwd_data_out;
  logic          stall_out;
  logic [WW-1:0] retired_instruction_out;
  logic [CW-1:0] retire_count_out;
  logic          mem_error_out;

  writeback_stage #(
    .WORD_WIDTH(WW), .REGISTER_INDEX_WIDTH(RW), .MEM_TIMEOUT(TMO), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instruction_in(instruction_in), .dst_reg_data_in(dst_reg_data_in),
    .mem_data_in(mem_data_in), .cu_mem_to_reg_in(cu_mem_to_reg_in),
    .cu_reg_write_in(cu_reg_write_in), .destination_register_in(destination_register_in),
    .cu_d_cache_access_in(cu_d_cache_access_in), .dcache_op_done_in(dcache_op_done_in),
    .rf_write_enable_out(rf_write_enable_out), .rf_write_index_out(rf_write_index_out),
    .rf_write_data_out(rf_write_data_out), .fwd_valid_out(fwd_valid_out),
    .fwd_index_out(fwd_index_out), .fwd_data_out(fwd_data_out),
    .stall_out(stall_out), .retired_instruction_out(retired_instruction_out),
    .retire_count_out(retire_count_out), .mem_error_out(mem_error_out)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          exp_count = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_retired = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic sample(input string tag, input bit exp_we, input logic [RW-1:0] exp_idx,
                        input logic [WW-1:0] exp_data, input bit exp_stall);
    check({tag, ".we"},      32'(rf_write_enable_out), 32'(exp_we));
    check({tag, ".fwd_v"},   32'(fwd_valid_out), 32'(exp_we));
    check({tag, ".stall"},   32'(stall_out), 32'(exp_stall));
    check({tag, ".count"},   32'(retire_count_out), 32'(exp_count % (1 << CW)));
    check({tag, ".err"},     32'(mem_error_out), 32'(exp_err));
    check({tag, ".retired"}, retired_instruction_out, exp_retired);
    if (exp_we) begin
      check({tag, ".idx"},      32'(rf_write_index_out), 32'(exp_idx));
      check({tag, ".data"},     rf_write_data_out, exp_data);
      check({tag, ".fwd_idx"},  32'(fwd_index_out), 32'(exp_idx));
      check({tag, ".fwd_data"}, fwd_data_out, exp_data);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".we"},      32'(rf_write_enable_out), 0);
    check({tag, ".idx"},     32'(rf_write_index_out), 0);
    check({tag, ".data"},    rf_write_data_out, 0);
    check({tag, ".fwd_v"},   32'(fwd_valid_out), 0);
    check({tag, ".fwd_idx"}, 32'(fwd_index_out), 0);
    check({tag, ".fwd_d"},   fwd_data_out, 0);
    check({tag, ".stall"},   32'(stall_out), 0);
    check({tag, ".retired"}, retired_instruction_out, 0);
    check({tag, ".count"},   32'(retire_count_out), 0);
    check({tag, ".err"},     32'(mem_error_out), 0);
  endtask

  // wait_n: 0 = done already high at issue, k = done at posedge k after entry,
  // >= TMO = done never arrives (timeout).
  task automatic run_op(input bit acc, input bit rw, input bit m2r, input logic [RW-1:0] dst,
                        input logic [WW-1:0] alu, input logic [WW-1:0] mem,
                        input logic [WW-1:0] instr, input int wait_n);
    bit          commit;
    logic [WW-1:0] wdata;
    logic [WW-1:0] m;
    commit = rw && (dst != 0);
    @(negedge clk);
    cu_d_cache_access_in = acc; cu_reg_write_in = rw; cu_mem_to_reg_in = m2r;
    destination_register_in = dst; dst_reg_data_in = alu; mem_data_in = mem;
    instruction_in = instr; dcache_op_done_in = acc && (wait_n == 0);
    if (!acc || wait_n == 0) begin
      wdata = (acc && m2r) ? mem : alu;
      if (!acc && !rw) commit = 1'b0;
      @(posedge clk); #1;
      if (commit) begin exp_count++; exp_retired = instr; end
      sample("op", commit, dst, wdata, 1'b0);
    end else begin
      @(posedge clk); #1;
      sample("entry", 1'b0, '0, '0, 1'b1);
      for (int j = 1; j < TMO; j++) begin
        @(negedge clk);
        cu_d_cache_access_in = 1'($urandom); cu_reg_write_in = 1'($urandom);
        cu_mem_to_reg_in = 1'($urandom); destination_register_in = RW'($urandom);
        dst_reg_data_in = $urandom; instruction_in = $urandom;
        mem_data_in = $urandom; m = mem_data_in;
        dcache_op_done_in = (j == wait_n);
        @(posedge clk); #1;
        if (j == wait_n) begin
          wdata = m2r ? m : alu;
          if (commit) begin exp_count++; exp_retired = instr; end
          sample("done", commit, dst, wdata, 1'b0);
          break;
        end else if (j == TMO - 1) begin
          exp_err = 1'b1;
          sample("timeout", 1'b0, '0, '0, 1'b0);
        end else begin
          sample("wait", 1'b0, '0, '0, 1'b1);
        end
      end
    end
    $display("op acc=%0d rw=%0d m2r=%0d dst=%0d wait=%0d count=%0d err=%0d bad=%0d",
             acc, rw, m2r, dst, wait_n, exp_count % (1 << CW), exp_err, bad);
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    cu_d_cache_access_in = 1'b1; cu_reg_write_in = 1'b1; cu_mem_to_reg_in = 1'b1;
    destination_register_in = 9; dcache_op_done_in = 1'b0; instruction_in = 32'h0BAD_0001;
    @(posedge clk); #1;
    sample("rst_entry", 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_count = 0; exp_err = 1'b0; exp_retired = '0;
    check_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    cu_d_cache_access_in = 1'b0; cu_reg_write_in = 1'b0;
    dcache_op_done_in = 1'b1; mem_data_in = 32'hFFFF_0000;
    @(posedge clk); #1;
    sample("rst_done", 1'b0, '0, '0, 1'b0);
    $display("reset mid-wait count=%0d bad=%0d", exp_count, bad);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1, 0, 5, 32'hDEADBEEF, 32'h0, 32'h1000_0001, 0);
    run_op(1, 1, 1, 7, 32'h5555_5555, 32'h0000_1234, 32'h1000_0002, 0);
    run_op(1, 1, 1, 9, 32'h6666_6666, 32'h0, 32'h1000_0003, 3);
    run_op(1, 1, 0, 10, 32'hA1A1_A1A1, 32'h0, 32'h1000_0004, 1);
    run_op(0, 1, 0, 0, 32'h7777_7777, 32'h0, 32'h1000_0005, 0);
    run_op(1, 0, 0, 3, 32'h8888_8888, 32'h0, 32'h1000_0006, 2);
    run_op(0, 1, 1, 11, 32'h0000_0011, 32'hEEEE_EEEE, 32'h1000_0007, 0);
    run_op(0, 1, 0, 12, 32'h0000_0012, 32'h0, 32'h1000_0008, 0);
    run_op(1, 1, 1, 4, 32'h0, 32'h0, 32'h1000_0009, TMO + 5);
    run_op(0, 1, 0, 13, 32'h0000_0013, 32'h0, 32'h1000_000A, 0);
    reset_mid_wait();
    for (int i = 0; i < 4; i++)
      run_op(0, 1, 0, RW'(i + 1), 32'(i), 32'h0, 32'h2000_0000 + 32'(i), 0);
    check("wrap", 32'(retire_count_out), 0);
    for (int i = 0; i < 200; i++) begin
      if (i == 100) reset_mid_wait();
      run_op(1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
             RW'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
             $urandom, $urandom, $urandom, $urandom_range(0, TMO + 1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
